adder_byte: RTL and testbench
=============================

ADDER_BYTE -- requirements
Module: adder_byte

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width; the block SHALL be verified at 8 only.
REQ-002 clk  input  1  rising-edge clock for the registered outputs.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  8  addend A, unsigned.
REQ-005 b  input  8  addend B, unsigned.
REQ-006 carry_in  input  1  carry into bit 0.
REQ-007 sum  output  8  combinational sum, a + b + carry_in modulo 256.
REQ-008 carry_out  output  1  combinational carry out of bit 7.
REQ-009 overflow  output  1  combinational two's-complement overflow: carry into bit 7 XOR carry out of bit 7.
REQ-010 sum_q  output  8  registered copy of sum.
REQ-011 carry_out_q  output  1  registered copy of carry_out.
REQ-012 overflow_q  output  1  registered copy of overflow.

Function
REQ-013 {carry_out, sum} SHALL equal the 9-bit result of a + b + carry_in for all 131072 input combinations.
REQ-014 sum, carry_out and overflow SHALL be purely combinational, with zero clock latency, and SHALL settle within 1 ns of simulated time after any input change.
REQ-015 Combinational outputs SHALL be independent of clk and rst_n; they SHALL be valid while reset is asserted.
REQ-016 Combinational outputs SHALL be free of X/Z whenever a, b and carry_in are known (0/1).
REQ-017 Wrap-around: 0xFF + 0x00 + 1 SHALL give sum 0x00 with carry_out 1; 0xFF + 0xFF + 1 SHALL give sum 0xFF with carry_out 1.
REQ-018 overflow SHALL be 1 when a and b have equal bit 7 and sum bit 7 differs from it, and 0 otherwise.
REQ-019 On each rising clk edge with rst_n high, sum_q, carry_out_q and overflow_q SHALL load the current combinational values (1-cycle latency).
REQ-020 There is no enable or handshake; the registers SHALL load on every cycle.

Reset
REQ-021 rst_n low SHALL immediately force sum_q = 0x00, carry_out_q = 0 and overflow_q = 0, without waiting for a clock edge.
REQ-022 Reset asserted mid-operation SHALL clear the registered outputs and leave the combinational outputs unaffected.
REQ-023 After rst_n deasserts, the first rising edge SHALL capture valid results.

Structure
REQ-024 The adder SHALL be a ripple-carry chain of eight instances of a full_adder sub-module, with ports a, b, cin, s and cout.
REQ-025 No shared package is needed; WIDTH is the only constant and SHALL remain local.
REQ-026 The output registers SHALL use a single always block with an asynchronous, active-low reset.

Verification
REQ-027 Exhaustive sweep: all {a, b, carry_in}, checked after 1 ns, -> {carry_out, sum} == a + b + carry_in, with no X; stop on the first mismatch.
REQ-028 Corner cases:
- a = 0x00, b = 0x00, carry_in = 0 -> sum 0x00, carry_out 0, overflow 0.
- a = 0xFF, b = 0x01, carry_in = 0 -> sum 0x00, carry_out 1, overflow 0.
REQ-029 Signed overflow: a = 0x7F, b = 0x01, carry_in = 0 -> sum 0x80, carry_out 0, overflow 1; a = 0x80, b = 0x80, carry_in = 0 -> sum 0x00, carry_out 1, overflow 1.
REQ-030 Register latency: apply a = 0x12, b = 0x34, carry_in = 1 -> sum_q 0x47 after the next rising edge, and not before it.
REQ-031 Asynchronous reset: drive rst_n low between clock edges while sum_q = 0x47 -> sum_q 0x00 immediately, while combinational sum remains 0x47.

Source files
------------

// File: rtl/full_adder.sv
// One-bit full adder; the ripple-carry cell of adder_byte.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_byte.sv
// Ripple-carry adder with combinational sum/carry/overflow and a registered copy
// of all three results.
module adder_byte #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             overflow_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign carry_out = carry[WIDTH];
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign overflow  = carry[WIDTH] ^ carry[WIDTH-1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
            overflow_q  <= overflow;
        end
    end

endmodule

// File: tb/tb_adder_byte.sv
// Self-checking bench for adder_byte: exhaustive combinational sweep, directed
// corner vectors, register latency and asynchronous reset behaviour.
module tb_adder_byte;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
        logic       ov;
    } result_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;
    logic [7:0] sum_q;
    logic       carry_out_q;
    logic       overflow_q;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    result_t model_q;

    adder_byte #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .overflow_q  (overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic result_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        result_t  r;
        logic [8:0] full;
        full  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        r.sum = full[7:0];
        r.co  = full[8];
        r.ov  = (x[7] == y[7]) && (full[7] != x[7]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered-output model: one-cycle copy, cleared at once by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= '0;
        else        model_q <= model(a, b, carry_in);
    end

    // Per-cycle comparison on the falling edge, away from the capture edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            result_t m;
            m = model(a, b, carry_in);
            check("cmp_sum",   {24'd0, sum},          {24'd0, m.sum});
            check("cmp_co",    {31'd0, carry_out},    {31'd0, m.co});
            check("cmp_ov",    {31'd0, overflow},     {31'd0, m.ov});
            check("cmp_sum_q", {24'd0, sum_q},        {24'd0, model_q.sum});
            check("cmp_co_q",  {31'd0, carry_out_q},  {31'd0, model_q.co});
            check("cmp_ov_q",  {31'd0, overflow_q},   {31'd0, model_q.ov});
        end
    end

    // Directed vector with literal expectations, checked against DUT and model.
    task automatic vec(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic [7:0] es, input logic eco, input logic eov);
        result_t m;
        @(negedge clk);
        #2;
        a = x; b = y; carry_in = ci;
        #1;
        m = model(x, y, ci);
        check("vec_sum",       {24'd0, sum},       {24'd0, es});
        check("vec_co",        {31'd0, carry_out}, {31'd0, eco});
        check("vec_ov",        {31'd0, overflow},  {31'd0, eov});
        check("model_pin",     {22'd0, m.sum, m.co, m.ov}, {22'd0, es, eco, eov});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a = 8'h00; b = 8'h00; carry_in = 1'b0;
        #3;
        check("reset_sum_q", {24'd0, sum_q},      32'h0);
        check("reset_co_q",  {31'd0, carry_out_q}, 32'h0);
        check("reset_ov_q",  {31'd0, overflow_q},  32'h0);

        // Combinational path must work while reset is held.
        a = 8'h12; b = 8'h34; carry_in = 1'b1;
        #1;
        check("comb_in_reset", {24'd0, sum}, 32'h47);
        check("q_in_reset",    {24'd0, sum_q}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep; stops at the first mismatch.
        for (int i = 0; i < 131072; i++) begin
            logic [16:0] v;
            result_t     m;
            int          e0;
            v = i[16:0];
            {a, b, carry_in} = v;
            #1;
            m  = model(a, b, carry_in);
            e0 = errors;
            check("sweep_x", {31'd0, $isunknown({carry_out, sum, overflow})}, 32'h0);
            check("sweep_sum", {22'd0, carry_out, sum, overflow}, {22'd0, m.co, m.sum, m.ov});
            if (errors != e0) break;
        end

        // Settle inputs so the register model realigns, then compare every cycle.
        @(negedge clk);
        #2;
        a = 8'h00; b = 8'h00; carry_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        cmp_en = 1;

        vec(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        vec(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        vec(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        vec(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);
        vec(8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0);
        vec(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
        vec(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);

        // Latency: new result appears only after the next rising edge.
        @(negedge clk);
        #2;
        a = 8'h12; b = 8'h34; carry_in = 1'b1;
        #1;
        check("lat_comb",   {24'd0, sum},   32'h47);
        check("lat_before", {24'd0, sum_q}, 32'h00);
        @(posedge clk);
        #1;
        check("lat_after_sum", {24'd0, sum_q},       32'h47);
        check("lat_after_co",  {31'd0, carry_out_q}, 32'h0);
        check("lat_after_ov",  {31'd0, overflow_q},  32'h0);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sum_q", {24'd0, sum_q}, 32'h00);
        check("async_comb",  {24'd0, sum},   32'h47);
        @(negedge clk);
        #2;
        check("held_sum_q", {24'd0, sum_q}, 32'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_sum_q", {24'd0, sum_q}, 32'h47);

        vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("ov_q", {23'd0, sum_q, overflow_q}, {23'd0, 8'h80, 1'b1});
        @(negedge clk);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
